pipe_stage_ctrl: RTL

- Valid/ready sequencer for an external chain of STAGES pipelined data registers, where each register is an enable-gated clocked register.
- Generates per-stage load enables and tracks per-stage valid bits. Empty stages collapse, so data advances into any bubble even while the output is stalled.
- Supports a one-cycle flush and a graceful drain with completion pulse.
- Sits between an upstream producer and a downstream consumer; the data registers themselves live outside this block.

---
 rtl/pipe_stage_ctrl_pkg.sv | 24 ++
 rtl/pipe_stage_ctrl_if.sv | 22 ++
 rtl/pipe_stage_ctrl_stats.sv | 39 +++
 rtl/pipe_stage_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/pipe_stage_ctrl_pkg.sv
// pipe_stage_ctrl_pkg: shared types and helpers for pipe_stage_ctrl.
// State enum, occupancy width helper, saturating increment.
package pipe_stage_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  function automatic int occ_w(input int stages);
    return $clog2(stages + 1);
  endfunction

  // w is the live width of v (1..64); stick at all-ones of that width
  function automatic logic [63:0] sat_inc(
    input logic [63:0] v,
    input int          w
  );
    logic [63:0] max;
    max = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max) ? max : v + 64'd1;
  endfunction

endpackage

// File: rtl/pipe_stage_ctrl_if.sv
// pipe_stage_ctrl_if: upstream/downstream valid/ready handshake bundle.
// slave = controller side, master = producer/consumer side.
interface pipe_stage_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid
  );

  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid
  );
endinterface

// File: rtl/pipe_stage_ctrl_stats.sv
// pipe_stage_ctrl_stats: saturating stall / transfer counters.
// Ports: clk_i, rst_i, valid_i, ready_i -> stall_o, xfer_o (CNT_W each).
module pipe_stage_ctrl_stats
  import pipe_stage_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             ready_i,
  output logic [CNT_W-1:0] stall_o,
  output logic [CNT_W-1:0] xfer_o
);
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] xfer_q, xfer_d;

  always_comb begin
    stall_d = stall_q;
    xfer_d  = xfer_q;
    if (valid_i && !ready_i)
      stall_d = CNT_W'(sat_inc(64'(stall_q), CNT_W));
    if (valid_i && ready_i)
      xfer_d = CNT_W'(sat_inc(64'(xfer_q), CNT_W));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
      xfer_q  <= '0;
    end else begin
      stall_q <= stall_d;
      xfer_q  <= xfer_d;
    end
  end

  assign stall_o = stall_q;
  assign xfer_o  = xfer_q;
endmodule

// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: valid/ready sequencer for an external register chain.
// Ports: clk, rst, hs (in/out handshake), flush, drain_req, stage_en,
// stage_valid, drain_done, busy, occupancy; stall_cycles/xfer_count
// exist only when PIPE_STAGE_CTRL_STATS_EN is defined.
module pipe_stage_ctrl
  import pipe_stage_ctrl_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  pipe_stage_ctrl_if.slave         hs,
  input  logic                     flush,
  input  logic                     drain_req,
  output logic [STAGES-1:0]        stage_en,
  output logic [STAGES-1:0]        stage_valid,
  output logic                     drain_done,
  output logic                     busy,
  output logic [occ_w(STAGES)-1:0] occupancy
`ifdef PIPE_STAGE_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0]         stall_cycles,
  output logic [CNT_W-1:0]         xfer_count
`endif
);
  localparam int OW = occ_w(STAGES);

  if (STAGES < 1 || STAGES > 16 || CNT_W < 1 || CNT_W > 64) begin : g_bad_cfg
    $error("pipe_stage_ctrl: parameter out of range");
  end

  state_e            state_q, state_d;
  logic [STAGES-1:0] v_q, v_d, en;
  logic [OW-1:0]     occ_q, occ_d;
  logic              done_q, done_d;
  logic              acc;

  // a stage may load when empty or when its contents move on
  always_comb begin
    en = '0;
    en[STAGES-1] = !v_q[STAGES-1] | hs.out_ready;
    for (int i = STAGES - 2; i >= 0; i--)
      en[i] = !v_q[i] | en[i+1];
  end

  assign hs.in_ready  = en[0] & (state_q == RUN) & !flush;
  assign hs.out_valid = v_q[STAGES-1];
  assign acc          = hs.in_valid & hs.in_ready;

  always_comb begin
    v_d = v_q;
    if (flush) begin
      v_d = '0;
    end else begin
      if (en[0]) v_d[0] = acc;
      for (int i = 1; i < STAGES; i++)
        if (en[i]) v_d[i] = v_q[i-1];
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < STAGES; i++)
      occ_d = occ_d + OW'(v_d[i]);
  end

  // drain ends once the next valid vector is empty; done is registered
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (drain_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (v_d == '0) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      v_q     <= '0;
      occ_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      occ_q   <= occ_d;
      done_q  <= done_d;
    end
  end

  assign stage_en    = en;
  assign stage_valid = v_q;
  assign drain_done  = done_q;
  assign busy        = (|v_q) | (state_q == DRAIN);
  assign occupancy   = occ_q;

`ifdef PIPE_STAGE_CTRL_STATS_EN
  pipe_stage_ctrl_stats #(
    .CNT_W (CNT_W)
  ) u_stats (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (hs.out_valid),
    .ready_i (hs.out_ready),
    .stall_o (stall_cycles),
    .xfer_o  (xfer_count)
  );
`endif
endmodule
